// File: rtl/mt_pkg.sv
// Shared definitions for the streaming matrix transposer: bank lifecycle
// states and small elaboration-time helpers.
package mt_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_e;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/transpose_bank.sv
// One matrix bank: row-wise storage, a mode flag captured per matrix, and a
// read mux that emits either a column (transpose) or a row (pass-through).
module transpose_bank
  import mt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int LANES  = max_int(N_ROWS, N_COLS),
  parameter int IDX_W  = $clog2(LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [N_COLS*DATA_W-1:0] wr_row,
  input  logic                     mode_we,
  input  logic                     mode_in,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic                     mode,
  output logic [LANES*DATA_W-1:0]  rd_row
);

  logic [DATA_W-1:0]       mem_r [N_ROWS][N_COLS];
  logic                    mode_r;
  logic [LANES*DATA_W-1:0] rd_row_s;

  // Mode flag, written only on the first accepted beat of a matrix
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_r <= 1'b0;
    end else if (mode_we) begin
      mode_r <= mode_in;
    end else begin
      mode_r <= mode_r;
    end
  end

  // Element storage; contents survive reset since occupancy is tracked by state
  always_ff @(posedge clk) begin
    for (int r = 0; r < N_ROWS; r++) begin
      if (wr_en && (wr_idx == IDX_W'(r))) begin
        for (int c = 0; c < N_COLS; c++) begin
          mem_r[r][c] <= wr_row[c*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Beat select: column rd_idx across rows, or row rd_idx across columns
  always_comb begin
    rd_row_s = {(LANES*DATA_W){1'b0}};
    if (mode_r) begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          rd_row_s[r*DATA_W +: DATA_W] |= (rd_idx == IDX_W'(c)) ? mem_r[r][c] : {DATA_W{1'b0}};
        end
      end
    end else begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          rd_row_s[c*DATA_W +: DATA_W] |= (rd_idx == IDX_W'(r)) ? mem_r[r][c] : {DATA_W{1'b0}};
        end
      end
    end
  end

  assign mode   = mode_r;
  assign rd_row = rd_row_s;

endmodule

// File: rtl/matrix_transpose_stream.sv
// Ping-pong streaming matrix transposer: rows stream into one bank while the
// other bank drains as columns (transpose) or rows (pass-through).
module matrix_transpose_stream
  import mt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  localparam int LANES = max_int(N_ROWS, N_COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [N_COLS*DATA_W-1:0] in_row,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [LANES*DATA_W-1:0]  out_row,
  output logic                     out_last
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(N_ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(N_COLS - 1);

  bank_state_e [1:0] state_r, state_s;
  logic              wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
  logic [IDX_W-1:0]  wr_cnt_r, wr_cnt_s, rd_cnt_r, rd_cnt_s;
  logic [1:0]        bank_wr_s, bank_mode_we_s, bank_mode_s;
  logic [1:0][LANES*DATA_W-1:0] bank_rd_s;
  logic              in_fire_s, out_fire_s, out_val_s, rd_last_s;
  logic [IDX_W-1:0]  beat_last_s;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    transpose_bank #(
      .DATA_W(DATA_W), .N_ROWS(N_ROWS), .N_COLS(N_COLS), .LANES(LANES), .IDX_W(IDX_W)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (bank_wr_s[b]),
      .wr_idx (wr_cnt_r),
      .wr_row (in_row),
      .mode_we(bank_mode_we_s[b]),
      .mode_in(ctrl),
      .rd_idx (rd_cnt_r),
      .mode   (bank_mode_s[b]),
      .rd_row (bank_rd_s[b])
    );
  end

  // Handshakes depend on bank state only, never on the opposite side's ready
  assign in_rdy      = (state_r[wr_ptr_r] == BANK_EMPTY) || (state_r[wr_ptr_r] == BANK_FILLING);
  assign out_val_s   = (state_r[rd_ptr_r] == BANK_FULL) || (state_r[rd_ptr_r] == BANK_DRAINING);
  assign in_fire_s   = in_val && in_rdy;
  assign out_fire_s  = out_val_s && out_rdy;
  assign beat_last_s = bank_mode_s[rd_ptr_r] ? COL_LAST : ROW_LAST;
  assign rd_last_s   = (rd_cnt_r >= beat_last_s);

  assign out_val  = out_val_s;
  assign out_last = out_val_s && rd_last_s;
  assign out_row  = out_val_s ? bank_rd_s[rd_ptr_r] : {(LANES*DATA_W){1'b0}};

  // Next-state: write side and read side never touch the same bank
  always_comb begin
    state_s        = state_r;
    wr_ptr_s       = wr_ptr_r;
    rd_ptr_s       = rd_ptr_r;
    wr_cnt_s       = wr_cnt_r;
    rd_cnt_s       = rd_cnt_r;
    bank_wr_s      = 2'b00;
    bank_mode_we_s = 2'b00;
    if (in_fire_s) begin
      bank_wr_s[wr_ptr_r]      = 1'b1;
      bank_mode_we_s[wr_ptr_r] = (state_r[wr_ptr_r] == BANK_EMPTY);
      if (wr_cnt_r >= ROW_LAST) begin
        state_s[wr_ptr_r] = BANK_FULL;
        wr_ptr_s          = ~wr_ptr_r;
        wr_cnt_s          = {IDX_W{1'b0}};
      end else begin
        state_s[wr_ptr_r] = BANK_FILLING;
        wr_cnt_s          = wr_cnt_r + IDX_W'(1);
      end
    end else begin
      wr_cnt_s = wr_cnt_r;
    end
    if (out_fire_s) begin
      if (rd_last_s) begin
        state_s[rd_ptr_r] = BANK_EMPTY;
        rd_ptr_s          = ~rd_ptr_r;
        rd_cnt_s          = {IDX_W{1'b0}};
      end else begin
        state_s[rd_ptr_r] = BANK_DRAINING;
        rd_cnt_s          = rd_cnt_r + IDX_W'(1);
      end
    end else begin
      rd_cnt_s = rd_cnt_r;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r[0] <= BANK_EMPTY;
      state_r[1] <= BANK_EMPTY;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      wr_cnt_r   <= {IDX_W{1'b0}};
      rd_cnt_r   <= {IDX_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      wr_cnt_r   <= wr_cnt_s;
      rd_cnt_r   <= rd_cnt_s;
    end
  end

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Self-checking bench: cycle table for the 4x4 cases, a queue-based matrix
// model under random traffic, and hand sequences for reset and a 2x4 instance.
module tb_matrix_transpose_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl, in_val, in_rdy, out_val, out_rdy, out_last;
  logic [31:0] in_row, out_row;
  logic        b_ctrl, b_in_val, b_in_rdy, b_out_val, b_out_rdy, b_out_last;
  logic [31:0] b_in_row, b_out_row;

  always #5 clk = ~clk;

  matrix_transpose_stream #(.DATA_W(8), .N_ROWS(4), .N_COLS(4)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .in_val(in_val), .in_rdy(in_rdy), .in_row(in_row),
    .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row), .out_last(out_last));

  matrix_transpose_stream #(.DATA_W(8), .N_ROWS(2), .N_COLS(4)) dut_b (
    .clk(clk), .rst(rst), .ctrl(b_ctrl), .in_val(b_in_val), .in_rdy(b_in_rdy), .in_row(b_in_row),
    .out_val(b_out_val), .out_rdy(b_out_rdy), .out_row(b_out_row), .out_last(b_out_last));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] elem(input int i, input int j);
    return 8'(16 * i + 10 + j);
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] row; logic ctrl; } beat_t;
  typedef struct { logic [31:0] row; logic last; } obeat_t;
  beat_t  src_q[$];
  obeat_t exp_q[$];
  int     pending, cur_rows, n_acc, p_val, p_rdy;
  logic   cur_ctrl;
  logic [7:0] cur_mat [4][4];
  logic   prev_stall;
  logic [31:0] prev_row;
  logic   prev_last;

  task automatic model_clear();
    src_q.delete(); exp_q.delete();
    pending = 0; cur_rows = 0; n_acc = 0; prev_stall = 1'b0;
  endtask

  task automatic accept(input beat_t b);
    obeat_t ob;
    if (cur_rows == 0) cur_ctrl = b.ctrl;
    for (int j = 0; j < 4; j++) cur_mat[cur_rows][j] = b.row[j*8 +: 8];
    cur_rows++;
    n_acc++;
    if (cur_rows == 4) begin
      for (int k = 0; k < 4; k++) begin
        for (int l = 0; l < 4; l++)
          ob.row[l*8 +: 8] = cur_ctrl ? cur_mat[l][k] : cur_mat[k][l];
        ob.last = (k == 3);
        exp_q.push_back(ob);
      end
      pending++;
      cur_rows = 0;
    end
  endtask

  task automatic push_matrix(input logic [7:0] m [4][4], input logic c0, input logic crest);
    beat_t b;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) b.row[j*8 +: 8] = m[r][j];
      b.ctrl = (r == 0) ? c0 : crest;
      src_q.push_back(b);
    end
  endtask

  task automatic step();
    obeat_t ob;
    beat_t  b;
    @(negedge clk);
    chk("in_rdy", 32'(in_rdy), 32'(pending < 2));
    chk("out_val", 32'(out_val), 32'(pending > 0));
    if (prev_stall) begin
      chk("hold_row", out_row, prev_row);
      chk("hold_last", 32'(out_last), 32'(prev_last));
    end
    out_rdy = (int'($urandom_range(99)) < p_rdy);
    if (src_q.size() > 0 && int'($urandom_range(99)) < p_val) begin
      in_val = 1'b1; in_row = src_q[0].row; ctrl = src_q[0].ctrl;
    end else begin
      in_val = 1'b0; in_row = $urandom; ctrl = 1'($urandom);
    end
    if (out_val && out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("out_extra", 32'(out_val), 32'(0));
      end else begin
        ob = exp_q.pop_front();
        chk("out_row", out_row, ob.row);
        chk("out_last", 32'(out_last), 32'(ob.last));
        if (ob.last) pending--;
      end
    end
    prev_stall = out_val && !out_rdy;
    prev_row   = out_row;
    prev_last  = out_last;
    if (in_val && in_rdy) begin
      b = src_q.pop_front();
      accept(b);
    end
  endtask

  task automatic run_until_drained(input int budget);
    for (int i = 0; i < budget && (src_q.size() > 0 || exp_q.size() > 0); i++) step();
    chk("drained", 32'(src_q.size() + exp_q.size()), 32'(0));
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic do_reset();
    in_val = 1'b0; b_in_val = 1'b0; out_rdy = 1'b1; b_out_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_val", 32'(out_val), 32'(0));
    chk("rst_out_last", 32'(out_last), 32'(0));
    chk("rst_out_row", out_row, 32'(0));
    chk("rst_b_out_val", 32'(b_out_val), 32'(0));
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    chk("post_rst_in_rdy", 32'(in_rdy), 32'(1));
    chk("post_rst_out_val", 32'(out_val), 32'(0));
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic in_val; logic [31:0] in_row; logic ctrl;
    logic exp_val; logic [31:0] exp_row; logic exp_last;
  } vec_t;
  vec_t tbl [13];

  logic [7:0] ref_m [4][4];
  logic [7:0] rnd_m [4][4];

  initial begin
    // Matrix 0 transposed then the same data passed through, back to back
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ref_m[i][j] = elem(i, j);
    for (int k = 0; k < 13; k++) begin
      tbl[k].in_val   = (k < 8);
      tbl[k].ctrl     = (k < 4);
      tbl[k].exp_val  = (k >= 4 && k < 12);
      tbl[k].exp_last = (k == 7 || k == 11);
      for (int j = 0; j < 4; j++) begin
        tbl[k].in_row[j*8 +: 8]  = elem(k % 4, j);
        tbl[k].exp_row[j*8 +: 8] = (k >= 4 && k < 8) ? elem(j, k - 4) :
                                   (k >= 8 && k < 12) ? elem(k - 8, j) : 8'h00;
      end
    end

    rst = 1'b0; ctrl = 1'b0; in_row = 32'h0; b_ctrl = 1'b0; b_in_row = 32'h0;
    model_clear();
    do_reset();

    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk("tbl_in_rdy", 32'(in_rdy), 32'(1));
      chk("tbl_out_val", 32'(out_val), 32'(tbl[k].exp_val));
      chk("tbl_out_last", 32'(out_last), 32'(tbl[k].exp_last));
      if (tbl[k].exp_val) chk("tbl_out_row", out_row, tbl[k].exp_row);
      in_val = tbl[k].in_val; in_row = tbl[k].in_row; ctrl = tbl[k].ctrl; out_rdy = 1'b1;
    end

    // 2x4 transpose: two rows in, four column beats out with zero upper lanes
    do_reset();
    @(negedge clk);
    b_in_val = 1'b1; b_ctrl = 1'b1; b_in_row = {elem(0, 3), elem(0, 2), elem(0, 1), elem(0, 0)};
    @(negedge clk);
    b_ctrl = 1'b0; b_in_row = {elem(1, 3), elem(1, 2), elem(1, 1), elem(1, 0)};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      b_in_val = 1'b0;
      chk("b_out_val", 32'(b_out_val), 32'(1));
      chk("b_out_row", b_out_row, {8'h00, 8'h00, elem(1, c), elem(0, c)});
      chk("b_out_last", 32'(b_out_last), 32'(c == 3));
    end
    @(negedge clk);
    chk("b_out_val_done", 32'(b_out_val), 32'(0));

    // Three matrices against a stalled consumer, then release
    do_reset();
    p_val = 100; p_rdy = 0;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) rnd_m[i][j] = 8'(16 * m + 4 * i + j);
      push_matrix(rnd_m, 1'(m != 1), 1'(m != 1));
    end
    repeat (10) step();
    chk("stall_accepted", 32'(n_acc), 32'(8));
    p_rdy = 100;
    run_until_drained(200);

    // ctrl changes after the first beat are ignored until the next matrix
    do_reset();
    p_val = 100; p_rdy = 100;
    push_matrix(ref_m, 1'b1, 1'b0);
    push_matrix(ref_m, 1'b0, 1'b0);
    run_until_drained(200);

    // Reset with a half-filled matrix, then a clean transpose
    do_reset();
    push_matrix(ref_m, 1'b0, 1'b0);
    step(); step();
    do_reset();
    p_val = 100; p_rdy = 100;
    push_matrix(ref_m, 1'b1, 1'b1);
    run_until_drained(200);

    // Random traffic with random per-beat ctrl
    do_reset();
    p_val = 75; p_rdy = 60;
    for (int m = 0; m < 16; m++) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) rnd_m[i][j] = 8'($urandom);
      push_matrix(rnd_m, 1'($urandom), 1'($urandom));
    end
    run_until_drained(3000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
